imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width (1024 words).
REQ-002 SHALL have parameter CNT_W, default ADDR_W+1, width of the word-count input.
REQ-003 SHALL have port clock  input  1  rising-edge clock shared with instruction memory.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle load request.
REQ-006 SHALL have port load_count  input  CNT_W  number of 32-bit words to load, sampled on start.
REQ-007 SHALL have port in_data  input  8  incoming byte.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port mem_data  output  32  instruction-memory write data.
REQ-011 SHALL have port mem_wraddress  output  ADDR_W  instruction-memory write word address.
REQ-012 SHALL have port mem_wren  output  1  instruction-memory write enable.
REQ-013 SHALL have port cpu_hold  output  1  processor held (PC frozen) while high.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port done  output  1  last load finished, sticky until next accepted start.
REQ-016 SHALL have port error  output  1  checksum mismatch on last load.

Function
REQ-017 SHALL implement states IDLE, RECV, WRITE, CHECK, DONE.
REQ-018 Byte transfer occurs only in a cycle where in_valid and in_ready are both high.
REQ-019 IDLE/DONE: start accepted, clear done/error, word counter and address to 0, latch load_count, go to RECV next cycle.
REQ-020 load_count above 2^ADDR_W SHALL clamp to 2^ADDR_W; load_count 0 SHALL go straight to DONE.
REQ-021 start while busy SHALL be ignored.
REQ-022 RECV: in_ready high; bytes assembled big-endian (first byte to bits 31:24); after the 4th byte go to WRITE.
REQ-023 WRITE: in_ready low; mem_wren high for exactly one cycle with mem_data = assembled word and mem_wraddress = word counter.
REQ-024 After WRITE, increment address; if words written equals latched count go to CHECK (macro on) or DONE, else RECV.
REQ-025 Latency from 4th byte handshake to mem_wren SHALL be 1 cycle; throughput 1 word per 5 cycles maximum.
REQ-026 Address SHALL never wrap: a 1024-word load ends at address 1023.
REQ-027 mem_wren SHALL be low in every state except WRITE.
REQ-028 cpu_hold and busy SHALL be high from the cycle after start acceptance until entry to DONE.
REQ-029 Gaps on in_valid SHALL only stall; partial bytes are retained.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE; in_ready, mem_wren, cpu_hold, busy, done, error = 0; mem_data, mem_wraddress, counters, checksum = 0.
REQ-031 Reset mid-load SHALL abandon the load; already-written words remain in memory; done stays 0.

Configuration
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN SHALL enable checksum: running 32-bit modulo sum of written words; CHECK state receives 4 further big-endian trailer bytes (in_ready high), compares, sets error on mismatch, then DONE.
REQ-033 Without IMEM_LOADER_CHECKSUM_EN: no CHECK state, no trailer, error tied 0, no checksum register.

Structure
REQ-034 State encoding enum and byte/word width constants SHALL live in shared package imem_pkg.
REQ-035 Byte-to-word assembly SHALL be sub-module byte_packer (shift register + 2-bit byte counter, word_valid pulse).

Verification
REQ-036 Reset then load_count=2, bytes 20 08 00 05 / 00 00 00 0C -> writes 0x20080005 at addr 0, 0x0000000C at addr 1; done=1, cpu_hold=0.
REQ-037 in_valid toggled every other cycle during a 1-word load of 0xDEADBEEF -> single write of 0xDEADBEEF, no extra mem_wren.
REQ-038 load_count=2047 -> exactly 1024 writes, last at address 1023, then done.
REQ-039 reset_n pulsed low after 6 bytes of a 3-word load -> outputs zero immediately, word 0 written, word 1 never written, done=0.
REQ-040 Macro on, words 0x00000001, 0xFFFFFFFF, trailer 00 00 00 00 -> error=0; trailer 00 00 00 01 -> error=1.
REQ-041 start asserted mid-load and load_count=0 after done -> mid-load start ignored; zero-count start reaches done with no mem_wren.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared widths and state encoding for the instruction-memory loader.
// The CHECK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// slave = loader side, master = byte source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 10
) ();
    import imem_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] mem_data;
    logic [ADDR_W-1:0] mem_wraddress;
    logic              mem_wren;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_data,
        output mem_wraddress,
        output mem_wren
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_data,
        input  mem_wraddress,
        input  mem_wren
    );

endinterface

// File: rtl/byte_packer.sv
// Big-endian byte-to-word shift register; word_valid flags the handshake
// that delivers the fourth byte, so the full word is in 'word' one cycle later.
module byte_packer
    import imem_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [1:0] byte_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (byte_valid) begin
            word     <= {word[WORD_W-BYTE_W-1:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word_valid = byte_valid && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads load_count big-endian words into instruction memory while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require and verify a 4-byte sum trailer.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] load_count,
    imem_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  count_q, written_q, clamped;
    logic [ADDR_W-1:0] addr_q;
    logic              fire, accept, last_word, word_valid;
    logic [WORD_W-1:0] word;

    assign clamped   = (load_count > MAX_WORDS) ? MAX_WORDS : load_count;
    assign fire      = bus.in_valid && bus.in_ready;
    assign last_word = (written_q + CNT_W'(1)) == count_q;

    // in_ready depends on state alone so the packer handshake has no comb loop
    assign bus.in_ready = (state == RECV)
`ifdef IMEM_LOADER_CHECKSUM_EN
                          || (state == CHECK)
`endif
                          ;

    assign busy              = (state != IDLE) && (state != DONE);
    assign cpu_hold          = busy;
    assign done              = (state == DONE);
    assign bus.mem_data      = word;
    assign bus.mem_wraddress = addr_q;

    byte_packer u_packer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (accept),
        .byte_in    (bus.in_data),
        .byte_valid (fire),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        bus.mem_wren = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (clamped == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (word_valid) state_nx = WRITE;
            end
            WRITE: begin
                bus.mem_wren = 1'b1;
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nx = CHECK;
`else
                    state_nx = DONE;
`endif
                end else begin
                    state_nx = RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (word_valid) state_nx = DONE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q;
    logic              error_q;
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // The last address is held rather than incremented so a full-memory load never wraps
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            written_q <= '0;
            addr_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                count_q   <= clamped;
                written_q <= '0;
                addr_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q     <= '0;
                error_q   <= 1'b0;
`endif
            end
            if (state == WRITE) begin
                written_q <= written_q + CNT_W'(1);
                if (!last_word) addr_q <= addr_q + ADDR_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q <= sum_q + word;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if ((state == CHECK) && word_valid)
                error_q <= ({word[WORD_W-BYTE_W-1:0], bus.in_data} != sum_q);
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; the expected memory image is
// simply "word i lands at address i" for the first min(count,1024) words.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [10:0] load_count;
    logic        cpu_hold, busy, done, error;

    imem_loader_if #(.ADDR_W(10)) bus ();

    imem_loader #(.ADDR_W(10), .CNT_W(11)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .load_count (load_count),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    logic [41:0] wr_q[$];

    // Every memory write seen, as {address, data}
    always @(negedge clock) begin
        if (bus.mem_wren === 1'b1) wr_q.push_back({bus.mem_wraddress, bus.mem_data});
    end

    function automatic logic [31:0] model_sum(input logic [31:0] words[$]);
        logic [31:0] s = 32'h0;
        foreach (words[i]) s = s + words[i];
        return s;
    endfunction

    task automatic start_load(input logic [10:0] cnt);
        wr_q.delete();
        start = 1'b1;
        load_count = cnt;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        if (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clock);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        if (t >= 50) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL handshake_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, t);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic finish_load(input logic [31:0] words[$]);
        int t = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(model_sum(words), 1'b0);
`else
        if (words.size() > 1024) $display("[TB] note: oversized word list");
`endif
        while (done !== 1'b1 && t < 40) begin
            @(negedge clock);
            t++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b0;
        load_count = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (2) @(negedge clock);
        vectors++;
        if ({bus.in_ready, bus.mem_wren, cpu_hold, busy, done, error} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b required 000000",
                     {bus.in_ready, bus.mem_wren, cpu_hold, busy, done, error});
        end
        vectors++;
        if (bus.mem_data !== 32'h0 || bus.mem_wraddress !== 10'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_bus: data=%h addr=%0d required 0/0", bus.mem_data, bus.mem_wraddress);
        end
        reset_n = 1'b1;
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_basic;
        logic [31:0] words[$];
        words = '{32'h20080005, 32'h0000000C};
        start_load(11'd2);
        vectors++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_hold: busy=%b cpu_hold=%b required 1/1", busy, cpu_hold);
        end
        send_word(words[0], 1'b0);
        vectors++;
        if (bus.mem_wren !== 1'b1 || bus.mem_data !== words[0] || bus.mem_wraddress !== 10'd0) begin
            miscompares++;
            $display("[TB] FAIL basic_latency: wren=%b data=%h addr=%0d required 1/%h/0",
                     bus.mem_wren, bus.mem_data, bus.mem_wraddress, words[0]);
        end
        send_word(words[1], 1'b0);
        finish_load(words);
        vectors++;
        if (wr_q.size() != 2) begin
            miscompares++;
            $display("[TB] FAIL basic_count: got %0d writes required 2", wr_q.size());
        end
        foreach (words[i]) begin
            vectors++;
            if (i >= wr_q.size() || wr_q[i] !== {10'(i), words[i]}) begin
                miscompares++;
                $display("[TB] FAIL basic_write%0d: got %h required %h", i,
                         (i < wr_q.size()) ? wr_q[i] : 42'h0, {10'(i), words[i]});
            end
        end
        vectors++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_done: done=%b hold=%b busy=%b error=%b required 1/0/0/0",
                     done, cpu_hold, busy, error);
        end
    endtask

    task automatic test_gaps;
        logic [31:0] words[$];
        words = '{32'hDEADBEEF};
        start_load(11'd1);
        send_word(words[0], 1'b1);
        finish_load(words);
        repeat (4) @(negedge clock);
        vectors++;
        if (wr_q.size() != 1 || wr_q[0] !== {10'd0, 32'hDEADBEEF}) begin
            miscompares++;
            $display("[TB] FAIL gaps_write: got %0d writes first %h required 1 of %h",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 42'h0, {10'd0, 32'hDEADBEEF});
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL gaps_done: got %b required 1", done);
        end
    endtask

    task automatic test_random;
        logic [31:0] words[$];
        for (int iter = 0; iter < 4; iter++) begin
            int n = $urandom_range(1, 6);
            bit gap = 1'($urandom_range(0, 1));
            words.delete();
            for (int k = 0; k < n; k++) words.push_back($urandom);
            start_load(11'(n));
            foreach (words[k]) send_word(words[k], gap);
            finish_load(words);
            vectors++;
            if (wr_q.size() != n) begin
                miscompares++;
                $display("[TB] FAIL random%0d_count: got %0d required %0d", iter, wr_q.size(), n);
            end
            foreach (words[k]) begin
                vectors++;
                if (k >= wr_q.size() || wr_q[k] !== {10'(k), words[k]}) begin
                    miscompares++;
                    $display("[TB] FAIL random%0d_write%0d: got %h required %h", iter, k,
                             (k < wr_q.size()) ? wr_q[k] : 42'h0, {10'(k), words[k]});
                end
            end
            vectors++;
            if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL random%0d_done: done=%b busy=%b error=%b required 1/0/0",
                         iter, done, busy, error);
            end
        end
    endtask

    task automatic test_clamp;
        logic [31:0] words[$];
        int bad = 0;
        for (int k = 0; k < 1024; k++) words.push_back($urandom);
        start_load(11'd2047);
        foreach (words[k]) send_word(words[k], 1'b0);
        finish_load(words);
        vectors++;
        if (wr_q.size() != 1024) begin
            miscompares++;
            $display("[TB] FAIL clamp_count: got %0d required 1024", wr_q.size());
        end
        foreach (words[k]) begin
            if (k >= wr_q.size() || wr_q[k] !== {10'(k), words[k]}) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL clamp_image: got %0d wrong writes required 0", bad);
        end
        vectors++;
        if (wr_q.size() == 0 || wr_q[wr_q.size()-1][41:32] !== 10'd1023) begin
            miscompares++;
            $display("[TB] FAIL clamp_last_addr: got %0d required 1023",
                     (wr_q.size() > 0) ? wr_q[wr_q.size()-1][41:32] : 10'd0);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clamp_done: got %b required 1", done);
        end
    endtask

    task automatic test_reset_midload;
        logic [31:0] w0, w1;
        w0 = $urandom;
        w1 = $urandom;
        start_load(11'd3);
        send_word(w0, 1'b0);
        send_byte(w1[31:24], 1'b0);
        send_byte(w1[23:16], 1'b0);
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.mem_wren, cpu_hold, busy, done, error} !== 6'b0 ||
            bus.mem_data !== 32'h0 || bus.mem_wraddress !== 10'h0) begin
            miscompares++;
            $display("[TB] FAIL midload_reset_outputs: flags=%b data=%h addr=%0d required 0",
                     {bus.in_ready, bus.mem_wren, cpu_hold, busy, done, error},
                     bus.mem_data, bus.mem_wraddress);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        vectors++;
        if (wr_q.size() != 1 || wr_q[0] !== {10'd0, w0}) begin
            miscompares++;
            $display("[TB] FAIL midload_writes: got %0d writes first %h required 1 of %h",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 42'h0, {10'd0, w0});
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midload_done: got %b required 0", done);
        end
    endtask

    task automatic test_zero_count;
        int busy_cycles = 0;
        start_load(11'd0);
        for (int k = 0; k < 3; k++) begin
            if (busy === 1'b1 || cpu_hold === 1'b1) busy_cycles++;
            @(negedge clock);
        end
        vectors++;
        if (done !== 1'b1 || busy_cycles != 0 || wr_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL zero_count: done=%b busy_cycles=%0d writes=%0d required 1/0/0",
                     done, busy_cycles, wr_q.size());
        end
    endtask

    task automatic test_start_ignored;
        logic [31:0] words[$];
        words = '{$urandom, $urandom};
        start_load(11'd2);
        send_byte(words[0][31:24], 1'b0);
        start = 1'b1;
        load_count = 11'd5;
        send_byte(words[0][23:16], 1'b0);
        start = 1'b0;
        send_byte(words[0][15:8], 1'b0);
        send_byte(words[0][7:0], 1'b0);
        send_word(words[1], 1'b0);
        finish_load(words);
        repeat (3) @(negedge clock);
        vectors++;
        if (wr_q.size() != 2 || wr_q[0] !== {10'd0, words[0]} || wr_q[1] !== {10'd1, words[1]}) begin
            miscompares++;
            $display("[TB] FAIL start_ignored_writes: got %0d writes required 2 (%h, %h)",
                     wr_q.size(), words[0], words[1]);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL start_ignored_done: got %b required 1", done);
        end
        test_zero_count();
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        for (int pass = 0; pass < 2; pass++) begin
            int t = 0;
            start_load(11'd2);
            send_word(32'h00000001, 1'b0);
            send_word(32'hFFFFFFFF, 1'b0);
            send_word(32'(pass), 1'b0);
            while (done !== 1'b1 && t < 40) begin
                @(negedge clock);
                t++;
            end
            vectors++;
            if (done !== 1'b1 || error !== 1'(pass)) begin
                miscompares++;
                $display("[TB] FAIL checksum%0d: done=%b error=%b required 1/%0d", pass, done, error, pass);
            end
        end
        start_load(11'd1);
        vectors++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL checksum_clear: error=%b busy=%b required 0/1", error, busy);
        end
        send_word(32'h12345678, 1'b0);
        send_word(32'h12345678, 1'b0);
        repeat (2) @(negedge clock);
    endtask
`endif

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clock);
        test_reset();
        test_basic();
        test_gaps();
        test_random();
        test_clamp();
        test_reset_midload();
        test_zero_count();
        test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
